// File: rtl/mux_scan_ctrl_if.sv
// Select/data/handshake bundle between the scan sequencer, the N:1 mux and the word consumer.
// slave = sequencer side; master = environment (mux model plus downstream consumer).
interface mux_scan_ctrl_if #(
    parameter int SIZE = 32
);
    localparam int SW = $clog2(SIZE);
    localparam int CW = SW + 1;

    logic            mux_scan_ctrl_port_start;
    logic [SW-1:0]   mux_scan_ctrl_port_first;
    logic [CW-1:0]   mux_scan_ctrl_port_count;
    logic [SW-1:0]   mux_scan_ctrl_port_sel;
    logic            mux_scan_ctrl_port_bit;
    logic            mux_scan_ctrl_port_busy;
    logic [SIZE-1:0] mux_scan_ctrl_port_data;
    logic            mux_scan_ctrl_port_valid;
    logic            mux_scan_ctrl_port_ready;
    logic            mux_scan_ctrl_port_err;

    modport slave (
        input  mux_scan_ctrl_port_start,
        input  mux_scan_ctrl_port_first,
        input  mux_scan_ctrl_port_count,
        input  mux_scan_ctrl_port_bit,
        input  mux_scan_ctrl_port_ready,
        output mux_scan_ctrl_port_sel,
        output mux_scan_ctrl_port_busy,
        output mux_scan_ctrl_port_data,
        output mux_scan_ctrl_port_valid,
        output mux_scan_ctrl_port_err
    );

    modport master (
        output mux_scan_ctrl_port_start,
        output mux_scan_ctrl_port_first,
        output mux_scan_ctrl_port_count,
        output mux_scan_ctrl_port_bit,
        output mux_scan_ctrl_port_ready,
        input  mux_scan_ctrl_port_sel,
        input  mux_scan_ctrl_port_busy,
        input  mux_scan_ctrl_port_data,
        input  mux_scan_ctrl_port_valid,
        input  mux_scan_ctrl_port_err
    );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Steps an N:1 mux select through a window of indices, one captured bit per cycle,
// and hands the assembled word downstream on valid/ready.
//
// state | meaning
// IDLE  | waiting for a start request
// SCAN  | sel driven, one mux bit captured per cycle into data[step]
// HOLD  | word complete, valid high until the consumer takes it
module mux_scan_ctrl #(
    parameter int SIZE = 32
) (
    input logic            mux_scan_ctrl_port_clk,
    input logic            mux_scan_ctrl_port_rst,
    mux_scan_ctrl_if.slave bus
);
    localparam int SW = $clog2(SIZE);
    localparam int CW = SW + 1;

    typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

    state_t          state;
    logic [CW-1:0]   step;
    logic [CW-1:0]   count_q;
    logic [SW-1:0]   sel_q;
    logic [SIZE-1:0] data_q;
    logic            busy_q;
    logic            valid_q;
    logic            err_q;

    logic start_legal;
    logic accepting;
    logic launch;
    logic reject;
    logic last_step;
    logic [SIZE-1:0] bit_mask;

    assign start_legal = (int'(bus.mux_scan_ctrl_port_count) >= 1)
                       && (int'(bus.mux_scan_ctrl_port_count) <= SIZE)
                       && (int'(bus.mux_scan_ctrl_port_first) < SIZE);
    assign accepting   = (state == IDLE) || ((state == HOLD) && bus.mux_scan_ctrl_port_ready);
    assign launch      = accepting && bus.mux_scan_ctrl_port_start && start_legal;
    assign reject      = accepting && bus.mux_scan_ctrl_port_start && !start_legal;
    assign last_step   = (step == count_q - 1'b1);
    // data is cleared at launch, so OR-ing in the current sample places it at position step
    assign bit_mask    = {{(SIZE-1){1'b0}}, bus.mux_scan_ctrl_port_bit} << step;

    always_ff @(posedge mux_scan_ctrl_port_clk) begin
        if (mux_scan_ctrl_port_rst) begin
            state   <= IDLE;
            step    <= '0;
            count_q <= '0;
            sel_q   <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= reject;
            if (launch) begin
                sel_q   <= bus.mux_scan_ctrl_port_first;
                step    <= '0;
                count_q <= bus.mux_scan_ctrl_port_count;
                data_q  <= '0;
                busy_q  <= 1'b1;
                valid_q <= 1'b0;
                state   <= SCAN;
            end else begin
                case (state)
                    SCAN: begin
                        data_q <= data_q | bit_mask;
                        if (last_step) begin
                            busy_q  <= 1'b0;
                            valid_q <= 1'b1;
                            state   <= HOLD;
                        end else begin
                            step  <= step + 1'b1;
                            sel_q <= (sel_q == SW'(SIZE - 1)) ? '0 : sel_q + 1'b1;
                        end
                    end
                    HOLD: begin
                        if (bus.mux_scan_ctrl_port_ready) begin
                            valid_q <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                    IDLE: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.mux_scan_ctrl_port_sel   = sel_q;
    assign bus.mux_scan_ctrl_port_data  = data_q;
    assign bus.mux_scan_ctrl_port_busy  = busy_q;
    assign bus.mux_scan_ctrl_port_valid = valid_q;
    assign bus.mux_scan_ctrl_port_err   = err_q;
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: a SIZE=32 instance under directed and random scans and a
// SIZE=10 instance for non-power-of-two wrap, both against a word-level reference.
module tb_mux_scan_ctrl;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    mux_scan_ctrl_if #(.SIZE(32)) a_if ();
    mux_scan_ctrl_if #(.SIZE(10)) b_if ();

    mux_scan_ctrl #(.SIZE(32)) dut_a (
        .mux_scan_ctrl_port_clk (clk),
        .mux_scan_ctrl_port_rst (rst),
        .bus                    (a_if.slave)
    );

    mux_scan_ctrl #(.SIZE(10)) dut_b (
        .mux_scan_ctrl_port_clk (clk),
        .mux_scan_ctrl_port_rst (rst),
        .bus                    (b_if.slave)
    );

    logic [31:0] mux_a;
    logic [9:0]  mux_b;
    assign a_if.mux_scan_ctrl_port_bit = mux_a[a_if.mux_scan_ctrl_port_sel];
    assign b_if.mux_scan_ctrl_port_bit = mux_b[b_if.mux_scan_ctrl_port_sel];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // expected word: step k samples mux input (first+k) mod size
    function automatic logic [31:0] ref_word(input logic [31:0] m, input int f, input int c, input int size);
        logic [31:0] w;
        w = '0;
        for (int k = 0; k < c; k++) w[k] = m[(f + k) % size];
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present_a(input int f, input int c);
        a_if.mux_scan_ctrl_port_start = 1'b1;
        a_if.mux_scan_ctrl_port_first = 5'(f);
        a_if.mux_scan_ctrl_port_count = 6'(c);
    endtask

    // Start must already be presented; takes the accepting edge, checks every scan cycle,
    // then holds the finished word for 'hold' cycles while start is toggled.
    task automatic scan_a(input int f, input int c, input int hold);
        logic [31:0] w;
        w = ref_word(mux_a, f, c, 32);
        tick();
        a_if.mux_scan_ctrl_port_start = 1'b0;
        for (int k = 0; k < c; k++) begin
            chk("a_busy", a_if.mux_scan_ctrl_port_busy, 1);
            chk("a_sel", a_if.mux_scan_ctrl_port_sel, (f + k) % 32);
            chk("a_valid_lo", a_if.mux_scan_ctrl_port_valid, 0);
            chk("a_err_scan", a_if.mux_scan_ctrl_port_err, 0);
            a_if.mux_scan_ctrl_port_ready = 1'($urandom_range(0, 1));
            a_if.mux_scan_ctrl_port_start = 1'($urandom_range(0, 1));
            tick();
        end
        a_if.mux_scan_ctrl_port_start = 1'b0;
        a_if.mux_scan_ctrl_port_ready = 1'b0;
        chk("a_valid_hi", a_if.mux_scan_ctrl_port_valid, 1);
        chk("a_busy_lo", a_if.mux_scan_ctrl_port_busy, 0);
        chk("a_data", a_if.mux_scan_ctrl_port_data, w);
        chk("a_sel_last", a_if.mux_scan_ctrl_port_sel, (f + c - 1) % 32);
        for (int h = 0; h < hold; h++) begin
            a_if.mux_scan_ctrl_port_start = 1'($urandom_range(0, 1));
            a_if.mux_scan_ctrl_port_first = 5'($urandom);
            a_if.mux_scan_ctrl_port_count = 6'($urandom_range(0, 63));
            tick();
            chk("a_hold_valid", a_if.mux_scan_ctrl_port_valid, 1);
            chk("a_hold_data", a_if.mux_scan_ctrl_port_data, w);
            chk("a_hold_sel", a_if.mux_scan_ctrl_port_sel, (f + c - 1) % 32);
            chk("a_hold_busy", a_if.mux_scan_ctrl_port_busy, 0);
            chk("a_hold_err", a_if.mux_scan_ctrl_port_err, 0);
        end
        a_if.mux_scan_ctrl_port_start = 1'b0;
    endtask

    task automatic accept_idle_a();
        a_if.mux_scan_ctrl_port_ready = 1'b1;
        a_if.mux_scan_ctrl_port_start = 1'b0;
        tick();
        a_if.mux_scan_ctrl_port_ready = 1'b0;
        chk("a_acc_valid", a_if.mux_scan_ctrl_port_valid, 0);
        chk("a_acc_busy", a_if.mux_scan_ctrl_port_busy, 0);
        chk("a_acc_err", a_if.mux_scan_ctrl_port_err, 0);
    endtask

    task automatic accept_illegal_a();
        logic [31:0] d;
        d = a_if.mux_scan_ctrl_port_data;
        a_if.mux_scan_ctrl_port_ready = 1'b1;
        present_a($urandom_range(0, 31), ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(33, 63));
        tick();
        a_if.mux_scan_ctrl_port_start = 1'b0;
        a_if.mux_scan_ctrl_port_ready = 1'b0;
        chk("a_hs_err", a_if.mux_scan_ctrl_port_err, 1);
        chk("a_hs_valid", a_if.mux_scan_ctrl_port_valid, 0);
        chk("a_hs_busy", a_if.mux_scan_ctrl_port_busy, 0);
        chk("a_hs_data", a_if.mux_scan_ctrl_port_data, d);
        tick();
        chk("a_hs_err_pulse", a_if.mux_scan_ctrl_port_err, 0);
        chk("a_hs_idle_busy", a_if.mux_scan_ctrl_port_busy, 0);
    endtask

    task automatic illegal_idle_a(input int f, input int c);
        logic [31:0] d;
        logic [4:0]  s;
        d = a_if.mux_scan_ctrl_port_data;
        s = a_if.mux_scan_ctrl_port_sel;
        present_a(f, c);
        tick();
        a_if.mux_scan_ctrl_port_start = 1'b0;
        chk("a_ill_err", a_if.mux_scan_ctrl_port_err, 1);
        chk("a_ill_busy", a_if.mux_scan_ctrl_port_busy, 0);
        chk("a_ill_valid", a_if.mux_scan_ctrl_port_valid, 0);
        chk("a_ill_data", a_if.mux_scan_ctrl_port_data, d);
        chk("a_ill_sel", a_if.mux_scan_ctrl_port_sel, s);
        tick();
        chk("a_ill_err_pulse", a_if.mux_scan_ctrl_port_err, 0);
        chk("a_ill_still_idle", a_if.mux_scan_ctrl_port_busy, 0);
    endtask

    task automatic scan_b(input int f, input int c);
        logic [31:0] w;
        w = ref_word({22'd0, mux_b}, f, c, 10);
        b_if.mux_scan_ctrl_port_start = 1'b1;
        b_if.mux_scan_ctrl_port_first = 4'(f);
        b_if.mux_scan_ctrl_port_count = 5'(c);
        tick();
        b_if.mux_scan_ctrl_port_start = 1'b0;
        for (int k = 0; k < c; k++) begin
            chk("b_busy", b_if.mux_scan_ctrl_port_busy, 1);
            chk("b_sel", b_if.mux_scan_ctrl_port_sel, (f + k) % 10);
            tick();
        end
        chk("b_valid", b_if.mux_scan_ctrl_port_valid, 1);
        chk("b_data", b_if.mux_scan_ctrl_port_data, w[9:0]);
        b_if.mux_scan_ctrl_port_ready = 1'b1;
        tick();
        b_if.mux_scan_ctrl_port_ready = 1'b0;
        chk("b_acc_valid", b_if.mux_scan_ctrl_port_valid, 0);
    endtask

    task automatic illegal_b(input int f, input int c);
        b_if.mux_scan_ctrl_port_start = 1'b1;
        b_if.mux_scan_ctrl_port_first = 4'(f);
        b_if.mux_scan_ctrl_port_count = 5'(c);
        tick();
        b_if.mux_scan_ctrl_port_start = 1'b0;
        chk("b_ill_err", b_if.mux_scan_ctrl_port_err, 1);
        chk("b_ill_busy", b_if.mux_scan_ctrl_port_busy, 0);
        tick();
        chk("b_ill_err_pulse", b_if.mux_scan_ctrl_port_err, 0);
        chk("b_ill_idle", b_if.mux_scan_ctrl_port_busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        total = 0;
        bad   = 0;
        mux_a = '0;
        mux_b = '0;
        rst   = 1'b1;
        a_if.mux_scan_ctrl_port_start = 1'b0;
        a_if.mux_scan_ctrl_port_first = '0;
        a_if.mux_scan_ctrl_port_count = '0;
        a_if.mux_scan_ctrl_port_ready = 1'b0;
        b_if.mux_scan_ctrl_port_start = 1'b0;
        b_if.mux_scan_ctrl_port_first = '0;
        b_if.mux_scan_ctrl_port_count = '0;
        b_if.mux_scan_ctrl_port_ready = 1'b0;
        repeat (3) tick();
        chk("rst_sel", a_if.mux_scan_ctrl_port_sel, 0);
        chk("rst_data", a_if.mux_scan_ctrl_port_data, 0);
        chk("rst_valid", a_if.mux_scan_ctrl_port_valid, 0);
        chk("rst_busy", a_if.mux_scan_ctrl_port_busy, 0);
        chk("rst_err", a_if.mux_scan_ctrl_port_err, 0);
        rst = 1'b0;
        tick();

        // full-width scan
        mux_a = 32'hA5A5_0F0F;
        present_a(0, 32);
        scan_a(0, 32, 0);
        chk("tp_full_word", a_if.mux_scan_ctrl_port_data, 64'hA5A5_0F0F);
        accept_idle_a();

        // wrap from 31 to 0
        mux_a = 32'h8000_0001;
        present_a(30, 4);
        scan_a(30, 4, 0);
        chk("tp_wrap_word", a_if.mux_scan_ctrl_port_data, 64'h6);
        accept_idle_a();

        illegal_idle_a(3, 0);
        illegal_idle_a(0, 33);

        // long hold then back-to-back restart with count=2
        mux_a = $urandom;
        present_a(7, 5);
        scan_a(7, 5, 5);
        mux_a = $urandom;
        a_if.mux_scan_ctrl_port_ready = 1'b1;
        present_a(12, 2);
        scan_a(12, 2, 0);
        accept_idle_a();

        // single-step scan
        mux_a = $urandom;
        present_a(31, 1);
        scan_a(31, 1, 1);
        accept_illegal_a();

        // reset during the third scan cycle of a count=8 scan
        mux_a = $urandom;
        present_a(5, 8);
        tick();
        a_if.mux_scan_ctrl_port_start = 1'b0;
        chk("rs_busy", a_if.mux_scan_ctrl_port_busy, 1);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rs_sel", a_if.mux_scan_ctrl_port_sel, 0);
        chk("rs_data", a_if.mux_scan_ctrl_port_data, 0);
        chk("rs_valid", a_if.mux_scan_ctrl_port_valid, 0);
        chk("rs_busy_lo", a_if.mux_scan_ctrl_port_busy, 0);
        chk("rs_err", a_if.mux_scan_ctrl_port_err, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("rs_no_valid", a_if.mux_scan_ctrl_port_valid, 0);
            chk("rs_no_busy", a_if.mux_scan_ctrl_port_busy, 0);
        end
        present_a(5, 8);
        scan_a(5, 8, 1);
        accept_idle_a();

        // non-power-of-two instance
        mux_b = 10'h3FF;
        scan_b(8, 3);
        chk("tp_b_word", b_if.mux_scan_ctrl_port_data, 64'h7);
        illegal_b(2, 0);
        illegal_b(10, 3);
        illegal_b(0, 11);
        for (int i = 0; i < 8; i++) begin
            mux_b = 10'($urandom);
            scan_b($urandom_range(0, 9), $urandom_range(1, 10));
        end

        // random scans on the 32-wide instance
        for (int i = 0; i < 30; i++) begin
            int f;
            int c;
            f = $urandom_range(0, 31);
            c = $urandom_range(1, 32);
            mux_a = $urandom;
            present_a(f, c);
            scan_a(f, c, $urandom_range(0, 3));
            case ($urandom_range(0, 2))
                0: accept_idle_a();
                1: accept_illegal_a();
                default: begin
                    f = $urandom_range(0, 31);
                    c = $urandom_range(1, 32);
                    mux_a = $urandom;
                    a_if.mux_scan_ctrl_port_ready = 1'b1;
                    present_a(f, c);
                    scan_a(f, c, 0);
                    accept_idle_a();
                end
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mux_scan_ctrl.md
# mux_scan_ctrl

Sequencer that drives the select input of an N:1 bit multiplexer (SIZE inputs), steps it through a programmable window of indices, and samples the multiplexer's single-bit output once per cycle. Captured bits are assembled into a SIZE-bit word and presented downstream on a valid/ready handshake. Sits directly upstream of the mux on the select path and directly downstream of it on the data path.

## Interface

- SIZE, 32, number of mux inputs; sel width is $clog2(SIZE); SIZE >= 2, need not be a power of two
- mux_scan_ctrl_port_clk  in  1  clock; all state on rising edge
- mux_scan_ctrl_port_rst  in  1  synchronous, active-high reset
- mux_scan_ctrl_port_start  in  1  request a scan; sampled only when accepting (IDLE, or HOLD with handshake completing)
- mux_scan_ctrl_port_first  in  $clog2(SIZE)  first select index, sampled with start
- mux_scan_ctrl_port_count  in  $clog2(SIZE)+1  bits to capture, legal 1..SIZE, sampled with start
- mux_scan_ctrl_port_sel  out  $clog2(SIZE)  registered select to mux
- mux_scan_ctrl_port_bit  in  1  mux output (combinational function of sel)
- mux_scan_ctrl_port_busy  out  1  high in SCAN
- mux_scan_ctrl_port_data  out  SIZE  captured word; bit k = sample at scan step k; bits >= count are 0
- mux_scan_ctrl_port_valid  out  1  data available (HOLD)
- mux_scan_ctrl_port_ready  in  1  downstream accepts data when valid & ready
- mux_scan_ctrl_port_err  out  1  one-cycle pulse: illegal start request rejected

## Operation

- States: IDLE, SCAN, HOLD. Internal: step counter ($clog2(SIZE)+1 bits), latched count.
- Start legality: count in 1..SIZE and first < SIZE. Illegal start in an accepting state: no state change, err pulses high for the next cycle; data/valid unchanged.
- IDLE + legal start: sel <= first, step <= 0, latch count, data <= 0, busy <= 1, -> SCAN.
- SCAN, every cycle: data[step] <= bit (bit reflects current registered sel). If step == count-1: busy <= 0, valid <= 1, -> HOLD. Else step <= step+1, sel <= (sel == SIZE-1) ? 0 : sel+1 (wrap at SIZE-1, not at 2^width).
- HOLD: data and sel stable, valid high until valid & ready. On handshake: valid <= 0; if legal start same cycle, begin new scan exactly as from IDLE (-> SCAN); else -> IDLE. Illegal start in that cycle: err pulse, -> IDLE.
- start while SCAN, or while HOLD without ready: ignored, no err.
- ready while not valid: ignored.
- sel retains last scanned index in IDLE/HOLD.

## Timing

- Reset values: state IDLE, sel 0, data 0, valid 0, busy 0, err 0, step 0. Reset mid-SCAN or in HOLD aborts; no valid produced, captured data discarded.
- Start accepted at edge E0: busy and sel=first visible after E0; sample k taken at edge E(k+1); valid visible after edge E(count); latency start->valid = count cycles.
- Back-to-back: handshake+start at edge Eh gives busy high after Eh, zero idle cycles between scans.
- Single-step scan (count=1): one SCAN cycle, valid one cycle after start.
- mux bit path is combinational from sel register through mux back into data register within one cycle; no extra pipeline stage.

## Test plan

- SIZE=32, mux inputs 0xA5A5_0F0F, start first=0 count=32, ready=1 -> valid 32 cycles after start, data=0xA5A5_0F0F, busy high exactly 32 cycles.
- SIZE=32, inputs 0x8000_0001, first=30 count=4 -> sel sequence 30,31,0,1; data=0x0000_0006 (bits: 0,1,1,0).
- SIZE=10, inputs 0x3FF, first=8 count=3 -> sel 8,9,0 (wraps at 9), data=0x007; count=0 or first=10 -> err pulse one cycle, state stays IDLE.
- ready held low 5 cycles after valid, start toggled during HOLD -> data/valid stable, start ignored, no err; then ready+start same cycle with count=2 -> valid drops, busy rises next cycle, second word after 2 cycles.
- Reset asserted in 3rd SCAN cycle of count=8 scan -> next cycle all outputs at reset values, no valid ever asserted for that scan; fresh start afterwards completes correctly.
